// File: rtl/fir_mac_sequencer.sv
// Time-shared FIR sequencer: one multiplier and one accumulator are reused
// across all taps, with a valid/ready sample input, a result output and a coefficient write port.
module fir_mac_sequencer #(
  parameter int TAPS = 3,
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int OW   = 16,
  parameter int AW   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [CW-1:0] cfg_data,
  output logic          cfg_err,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          busy
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0]   TAPS_W = (AW + 1)'(TAPS);
  localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     x    [DEPTH];
  logic [CW-1:0]     coef [DEPTH];
  logic [OW-1:0]     acc;
  logic [OW-1:0]     sum;
  logic [AW-1:0]     k;
  logic [DW+CW-1:0]  prod;
  logic              accept;
  logic              cfg_ok;

  // Arrays are padded to 2^AW entries so the tap index never runs out of range;
  // entries at or above TAPS stay zero.
  assign prod = {{CW{1'b0}}, x[k]} * {{DW{1'b0}}, coef[k]};
  assign sum  = acc + OW'(prod);

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    cfg_ok    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        cfg_ok   = cfg_we && ({1'b0, cfg_addr} < TAPS_W);
        if (in_valid) state_d = MAC;
      end
      MAC: begin
        busy = 1'b1;
        if (k == K_LAST) state_d = OUT;
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        x[j]    <= '0;
        coef[j] <= '0;
      end
      acc      <= '0;
      k        <= '0;
      out_data <= '0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_ok) coef[cfg_addr] <= cfg_data;
      if (accept) begin
        x[0] <= in_data;
        for (int unsigned j = 1; j < TAPS; j++) x[j] <= x[j-1];
        acc <= '0;
        k   <= '0;
      end else if (state_q == MAC) begin
        acc <= sum;
        k   <= k + 1'b1;
        if (k == K_LAST) out_data <= sum;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: directed and random samples against a sum-of-products
// reference over a modelled delay line and coefficient set.
module tb_fir_mac_sequencer;

  localparam int TAPS = 3;
  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int OW   = 16;
  localparam int AW   = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [CW-1:0] cfg_data;
  logic          cfg_err;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          busy;

  fir_mac_sequencer #(.TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int coef_m [TAPS];
  int x_m    [TAPS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < TAPS; i++) begin
      coef_m[i] = 0;
      x_m[i]    = 0;
    end
  endtask

  // Reference: newest sample at tap 0, result = sum of coef*sample wrapped to OW bits.
  task automatic push_model(input int s, output int e);
    int total;
    for (int i = TAPS - 1; i > 0; i--) x_m[i] = x_m[i-1];
    x_m[0] = s;
    total = 0;
    for (int i = 0; i < TAPS; i++) total += coef_m[i] * x_m[i];
    e = total % (1 << OW);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    @(negedge clk);
  endtask

  task automatic cfg_write(input int a, input int d, input bit exp_err);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = CW'(d);
    @(negedge clk);
    cfg_we = 1'b0;
    chk("cfg_err_pulse", cfg_err, exp_err);
    if (!exp_err) coef_m[a] = d;
    @(negedge clk);
    chk("cfg_err_clear", cfg_err, 0);
  endtask

  // Called at a negedge in IDLE; returns at a negedge back in IDLE.
  task automatic run_sample(input int s, input int hold, input bit poke, input bit mac_cfg);
    int e;
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_data = DW'(s);
    push_model(s, e);
    if (hold > 0) out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0;
    chk("busy_mac", busy, 1);
    chk("in_ready_mac", in_ready, 0);
    if (mac_cfg) begin cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 8'd9; end
    for (int i = 1; i <= TAPS; i++) begin
      @(negedge clk);
      if (mac_cfg && i == 1) begin cfg_we = 1'b0; chk("cfg_err_mac", cfg_err, 1); end
      if (mac_cfg && i == 2) chk("cfg_err_mac_clear", cfg_err, 0);
      chk("out_valid_latency", out_valid, (i == TAPS));
    end
    chk("out_data", out_data, e);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin in_valid = (i == 1); in_data = DW'($urandom); end
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, e);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("out_valid_clear", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
    chk("out_data_keep", out_data, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    do_reset();
    chk("post_rst_in_ready", in_ready, 1);

    // Sequence with coef {1,2,3}: 10, 40, 100, 120
    cfg_write(0, 1, 0); cfg_write(1, 2, 0); cfg_write(2, 3, 0);
    run_sample(10, 0, 0, 0);
    run_sample(20, 0, 0, 0);
    run_sample(30, 0, 0, 0);
    run_sample(0, 0, 0, 0);

    // Overflow wrap: 65025, 64514, 64003
    do_reset();
    cfg_write(0, 255, 0); cfg_write(1, 255, 0); cfg_write(2, 255, 0);
    run_sample(255, 0, 0, 0);
    run_sample(255, 0, 0, 0);
    run_sample(255, 0, 0, 0);

    // Backpressure with an ignored sample offer
    run_sample(17, 5, 1, 0);

    // Rejected writes: during MAC and out-of-range address in IDLE
    do_reset();
    cfg_write(0, 1, 0); cfg_write(1, 2, 0); cfg_write(2, 3, 0);
    run_sample(10, 0, 0, 1);
    run_sample(20, 0, 0, 0);
    cfg_write(3, 77, 1);
    run_sample(30, 0, 0, 0);

    // Write and sample on the same edge: 5*4 = 20
    do_reset();
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd5; coef_m[0] = 5;
    run_sample(4, 0, 0, 0);

    // Reset during the second MAC cycle
    cfg_write(1, 3, 0);
    in_valid = 1'b1; in_data = 8'd99;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_valid", out_valid, 0);
    end
    cfg_write(0, 1, 0);
    run_sample(7, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 16; n++) begin
      int a;
      if ($urandom_range(0, 1) == 1) begin
        a = $urandom_range(0, 3);
        cfg_write(a, $urandom_range(0, 255), (a >= TAPS));
      end
      run_sample($urandom_range(0, 255), $urandom_range(0, 3), 1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
